// File: rtl/writeback_stage_reg_if.sv
// MEM/WB stage bundle: MEM-stage results and stage controls in, register-file write port out.
interface writeback_stage_reg_if #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             in_RegWrite;
  logic [RA_W-1:0]  in_rd;
  logic [1:0]       in_wb_sel;
  logic [2:0]       in_ld_funct3;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_mem_data;
  logic [XLEN-1:0]  in_pc_plus4;
  logic [XLEN-1:0]  in_imm;
  logic             wb_valid;
  logic             wb_RegWrite;
  logic [RA_W-1:0]  wb_rd;
  logic [XLEN-1:0]  wb_registerout;
  logic             wb_ld_fault;
  logic [CNT_W-1:0] wb_retired;

  modport master (
    output stall, flush, in_valid, in_RegWrite, in_rd, in_wb_sel, in_ld_funct3,
           in_alu_result, in_mem_data, in_pc_plus4, in_imm,
    input  wb_valid, wb_RegWrite, wb_rd, wb_registerout, wb_ld_fault, wb_retired
  );

  modport slave (
    input  stall, flush, in_valid, in_RegWrite, in_rd, in_wb_sel, in_ld_funct3,
           in_alu_result, in_mem_data, in_pc_plus4, in_imm,
    output wb_valid, wb_RegWrite, wb_rd, wb_registerout, wb_ld_fault, wb_retired
  );
endinterface

// File: rtl/writeback_stage_reg.sv
// Registered MEM/WB writeback stage: result select, load extraction/extension,
// misalignment fault, x0 write suppression and a retired-instruction counter.
module writeback_stage_reg #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_stage_reg_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int SH_W  = $clog2(XLEN) + 1;

  logic             valid_reg;
  logic             regwrite_reg;
  logic [RA_W-1:0]  rd_reg;
  logic [1:0]       wb_sel_reg;
  logic [2:0]       funct3_reg;
  logic [XLEN-1:0]  alu_reg;
  logic [XLEN-1:0]  mem_reg;
  logic [XLEN-1:0]  pc4_reg;
  logic [XLEN-1:0]  imm_reg;
  logic [CNT_W-1:0] retired_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      wb_sel_reg   <= '0;
      funct3_reg   <= '0;
      alu_reg      <= '0;
      mem_reg      <= '0;
      pc4_reg      <= '0;
      imm_reg      <= '0;
    end else if (bus.flush) begin
      valid_reg    <= 1'b0;
    end else if (!bus.stall) begin
      valid_reg    <= bus.in_valid;
      regwrite_reg <= bus.in_RegWrite;
      rd_reg       <= bus.in_rd;
      wb_sel_reg   <= bus.in_wb_sel;
      funct3_reg   <= bus.in_ld_funct3;
      alu_reg      <= bus.in_alu_result;
      mem_reg      <= bus.in_mem_data;
      pc4_reg      <= bus.in_pc_plus4;
      imm_reg      <= bus.in_imm;
    end
  end

  // A held entry retires only on the cycle it leaves, so a stalled entry counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_reg <= '0;
    end else if (valid_reg && !bus.stall) begin
      retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  logic [OFF_W-1:0] off;
  logic [XLEN-1:0]  lane;
  logic [XLEN-1:0]  lane_left;
  logic [SH_W-1:0]  ext_sh;
  logic [XLEN-1:0]  load_val;
  logic             ld_bad;
  logic             ld_fault;
  logic [XLEN-1:0]  result;

  assign off  = alu_reg[OFF_W-1:0];
  assign lane = mem_reg >> {off, 3'b000};

  // Width extension: park the field at the top, then shift back logically or arithmetically.
  always_comb begin
    ext_sh = '0;
    case (funct3_reg[1:0])
      2'b00:   ext_sh = SH_W'(XLEN - 8);
      2'b01:   ext_sh = SH_W'(XLEN - 16);
      2'b10:   ext_sh = SH_W'(XLEN - 32);
      default: ext_sh = '0;
    endcase
  end

  assign lane_left = lane << ext_sh;
  assign load_val  = funct3_reg[2] ? (lane_left >> ext_sh)
                                   : unsigned'($signed(lane_left) >>> ext_sh);

  always_comb begin
    ld_bad = 1'b0;
    case (funct3_reg)
      3'b000, 3'b100: ld_bad = 1'b0;
      3'b001, 3'b101: ld_bad = off[0];
      3'b010, 3'b110: ld_bad = |off[1:0];
      3'b011:         ld_bad = (|off) || (XLEN == 32);
      default:        ld_bad = 1'b1;
    endcase
    // RV32 has no doubleword or zero-extended word loads.
    if (XLEN == 32 && funct3_reg == 3'b110) ld_bad = 1'b1;
  end

  assign ld_fault = valid_reg && (wb_sel_reg == 2'b01) && ld_bad;

  always_comb begin
    result = '0;
    case (wb_sel_reg)
      2'b00:   result = alu_reg;
      2'b01:   result = load_val;
      2'b10:   result = pc4_reg;
      default: result = imm_reg;
    endcase
  end

  assign bus.wb_valid       = valid_reg;
  assign bus.wb_rd          = rd_reg;
  assign bus.wb_ld_fault    = ld_fault;
  assign bus.wb_registerout = ld_fault ? '0 : result;
  assign bus.wb_RegWrite    = valid_reg && regwrite_reg && (|rd_reg) && !ld_fault;
  assign bus.wb_retired     = retired_reg;
endmodule

// File: tb/tb_writeback_stage_reg.sv
// Directed bench for writeback_stage_reg with an entry-level reference model and per-cycle compare.
module tb_writeback_stage_reg;
  localparam int XLEN  = 64;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam logic [63:0] MEMW = 64'h8877665544332211;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  writeback_stage_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [63:0] pc4;
    logic [63:0] imm;
  } entry_t;

  entry_t     m_e;
  logic [3:0] m_cnt;

  // Reference model: the entry currently held by the stage and the retire count.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_e   <= '0;
      m_cnt <= '0;
    end else begin
      if (m_e.v && !bus.stall) m_cnt <= m_cnt + 4'd1;
      if (bus.flush) m_e.v <= 1'b0;
      else if (!bus.stall)
        m_e <= {bus.in_valid, bus.in_RegWrite, bus.in_rd, bus.in_wb_sel, bus.in_ld_funct3,
                bus.in_alu_result, bus.in_mem_data, bus.in_pc_plus4, bus.in_imm};
    end
  end

  function automatic logic exp_fault(entry_t e);
    int n;
    int o;
    n = 1 << e.f3[1:0];
    o = int'(e.alu[2:0]);
    return e.v && (e.sel == 2'b01) && ((e.f3 == 3'd7) || ((o % n) != 0));
  endfunction

  function automatic logic [63:0] exp_load(entry_t e);
    int n;
    int o;
    logic [63:0] v;
    logic [63:0] mask;
    n = 1 << e.f3[1:0];
    o = int'(e.alu[2:0]);
    v = e.mem >> (8 * o);
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!e.f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_out(entry_t e);
    if (exp_fault(e)) return 64'd0;
    case (e.sel)
      2'b00:   return e.alu;
      2'b01:   return exp_load(e);
      2'b10:   return e.pc4;
      default: return e.imm;
    endcase
  endfunction

  function automatic logic exp_rw(entry_t e);
    return e.v && e.rw && (e.rd != 5'd0) && !exp_fault(e);
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("wb_valid",       64'(bus.wb_valid),    64'(m_e.v));
      cmp("wb_RegWrite",    64'(bus.wb_RegWrite), 64'(exp_rw(m_e)));
      cmp("wb_rd",          64'(bus.wb_rd),       64'(m_e.rd));
      cmp("wb_registerout", bus.wb_registerout,   exp_out(m_e));
      cmp("wb_ld_fault",    64'(bus.wb_ld_fault), 64'(exp_fault(m_e)));
      cmp("wb_retired",     64'(bus.wb_retired),  64'(m_cnt));
    end
  end

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] mem,
                       input logic [63:0] pc4, input logic [63:0] imm,
                       input logic st, input logic fl);
    @(negedge clk);
    bus.in_valid      = v;
    bus.in_RegWrite   = rw;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_ld_funct3  = f3;
    bus.in_alu_result = alu;
    bus.in_mem_data   = mem;
    bus.in_pc_plus4   = pc4;
    bus.in_imm        = imm;
    bus.stall         = st;
    bus.flush         = fl;
    $display("txn v=%0d rw=%0d rd=%0d sel=%0d f3=%0d alu=%h stall=%0d flush=%0d",
             v, rw, rd, sel, f3, alu, st, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_RegWrite = 1'b0;
    bus.in_rd = '0; bus.in_wb_sel = '0; bus.in_ld_funct3 = '0; bus.in_alu_result = '0;
    bus.in_mem_data = '0; bus.in_pc_plus4 = '0; bus.in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_valid",    64'(bus.wb_valid), 64'd0);
    cmp("reset_regwrite", 64'(bus.wb_RegWrite), 64'd0);
    cmp("reset_out",      bus.wb_registerout, 64'd0);
    cmp("reset_retired",  64'(bus.wb_retired), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Result select
    drive(1, 1, 5, 2'b00, 3'd0, 64'h1234, MEMW, 64'h104, 64'hABCD000, 0, 0);
    cmp("alu_rw", 64'(bus.wb_RegWrite), 64'd1);
    cmp("alu_rd", 64'(bus.wb_rd), 64'd5);
    cmp("alu_out", bus.wb_registerout, 64'h1234);
    drive(1, 1, 5, 2'b10, 3'd0, 64'h1234, MEMW, 64'h104, 64'hABCD000, 0, 0);
    cmp("pc4_out", bus.wb_registerout, 64'h104);
    drive(1, 1, 5, 2'b11, 3'd0, 64'h1234, MEMW, 64'h104, 64'hABCD000, 0, 0);
    cmp("imm_out", bus.wb_registerout, 64'hABCD000);

    // Loads
    drive(1, 1, 7, 2'b01, 3'd0, 64'h1007, MEMW, 0, 0, 0, 0);
    cmp("lb_off7", bus.wb_registerout, 64'hFFFFFFFFFFFFFF88);
    drive(1, 1, 7, 2'b01, 3'd4, 64'h1007, MEMW, 0, 0, 0, 0);
    cmp("lbu_off7", bus.wb_registerout, 64'h88);
    drive(1, 1, 7, 2'b01, 3'd1, 64'h1002, MEMW, 0, 0, 0, 0);
    cmp("lh_off2", bus.wb_registerout, 64'h4433);
    drive(1, 1, 7, 2'b01, 3'd2, 64'h1004, MEMW, 0, 0, 0, 0);
    cmp("lw_off4", bus.wb_registerout, 64'hFFFFFFFF88776655);
    drive(1, 1, 7, 2'b01, 3'd6, 64'h1004, MEMW, 0, 0, 0, 0);
    cmp("lwu_off4", bus.wb_registerout, 64'h88776655);
    drive(1, 1, 7, 2'b01, 3'd3, 64'h1000, MEMW, 0, 0, 0, 0);
    cmp("ld_off0", bus.wb_registerout, MEMW);

    // Faults and x0 suppression
    drive(1, 1, 7, 2'b01, 3'd1, 64'h1001, MEMW, 0, 0, 0, 0);
    cmp("lh_off1_fault", 64'(bus.wb_ld_fault), 64'd1);
    cmp("lh_off1_rw", 64'(bus.wb_RegWrite), 64'd0);
    cmp("lh_off1_out", bus.wb_registerout, 64'd0);
    drive(1, 1, 7, 2'b01, 3'd3, 64'h1004, MEMW, 0, 0, 0, 0);
    cmp("ld_off4_fault", 64'(bus.wb_ld_fault), 64'd1);
    cmp("ld_off4_out", bus.wb_registerout, 64'd0);
    cmp("retired_after_fault", 64'(bus.wb_retired), 64'd10);
    drive(1, 1, 0, 2'b00, 3'd0, 64'h55, MEMW, 0, 0, 0, 0);
    cmp("x0_rw", 64'(bus.wb_RegWrite), 64'd0);
    cmp("x0_fault", 64'(bus.wb_ld_fault), 64'd0);
    cmp("retired_fault_counted", 64'(bus.wb_retired), 64'd11);

    // Stall holds A for three cycles while B is presented
    drive(1, 1, 9, 2'b00, 3'd0, 64'hAAAA, MEMW, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 10, 2'b00, 3'd0, 64'hBBBB, MEMW, 0, 0, 1, 0);
      cmp("stall_out", bus.wb_registerout, 64'hAAAA);
      cmp("stall_rd", 64'(bus.wb_rd), 64'd9);
      cmp("stall_rw", 64'(bus.wb_RegWrite), 64'd1);
      cmp("stall_retired", 64'(bus.wb_retired), 64'd12);
    end
    drive(0, 0, 0, 2'b00, 3'd0, 0, 0, 0, 0, 0, 0);
    cmp("stall_retire_once", 64'(bus.wb_retired), 64'd13);

    // Flush with stall, then flush alone
    drive(1, 1, 11, 2'b00, 3'd0, 64'hCCCC, MEMW, 0, 0, 0, 0);
    drive(1, 1, 12, 2'b00, 3'd0, 64'hDDDD, MEMW, 0, 0, 1, 1);
    cmp("flush_stall_valid", 64'(bus.wb_valid), 64'd0);
    cmp("flush_stall_rw", 64'(bus.wb_RegWrite), 64'd0);
    drive(1, 1, 13, 2'b00, 3'd0, 64'hEEEE, MEMW, 0, 0, 0, 0);
    drive(1, 1, 14, 2'b00, 3'd0, 64'hFFFF, MEMW, 0, 0, 0, 1);
    cmp("flush_valid", 64'(bus.wb_valid), 64'd0);
    cmp("flush_retire", 64'(bus.wb_retired), 64'd14);

    // Asynchronous reset while a valid entry is held by stall
    drive(1, 1, 3, 2'b00, 3'd0, 64'h77, MEMW, 0, 0, 0, 0);
    drive(1, 1, 4, 2'b00, 3'd0, 64'h88, MEMW, 0, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    cmp("async_valid", 64'(bus.wb_valid), 64'd0);
    cmp("async_rw", 64'(bus.wb_RegWrite), 64'd0);
    cmp("async_rd", 64'(bus.wb_rd), 64'd0);
    cmp("async_out", bus.wb_registerout, 64'd0);
    cmp("async_retired", 64'(bus.wb_retired), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.in_valid = 1'b0;

    // Counter wrap: 17 retirements on a 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 5'(i), 2'b00, 3'd0, 64'(i), MEMW, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 2'b00, 3'd0, 0, 0, 0, 0, 0, 0);
    cmp("wrap_retired", 64'(bus.wb_retired), 64'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
